// File: rtl/row_render_seq.sv
// Sequential wall-column renderer: latches per-line wall parameters, tracks the
// vertical span with a small FSM and steps a fixed-point texture-v accumulator.
module row_render_seq #(
  parameter int H_VIEW = 640,
  parameter int HPOS_W = 10,
  parameter int SIZE_W = 11,
  parameter int TEX_W  = 6,
  parameter int FRAC_W = 10
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    line_start,
  input  logic                    px_en,
  input  logic                    side,
  input  logic [SIZE_W-1:0]       size,
  input  logic [TEX_W-1:0]        texu,
  input  logic [TEX_W+FRAC_W-1:0] vinit,
  input  logic [TEX_W+FRAC_W-1:0] vstep,
  input  logic                    mode,
  input  logic [HPOS_W-1:0]       hpos,
  output logic [5:0]              rgb,
  output logic                    hit,
  output logic [TEX_W-1:0]        texv
);
  localparam int ACC_W = TEX_W + FRAC_W;
  localparam int EW    = SIZE_W + 1;
  localparam logic [EW-1:0] HALF_X = EW'(H_VIEW / 2);
  localparam logic [EW-1:0] LAST_X = EW'(H_VIEW - 1);

  typedef enum logic [1:0] {IDLE, ARMED, INSIDE, DONE} state_t;

  state_t              state;
  logic                side_q;
  logic [TEX_W-1:0]    texu_q;
  logic [ACC_W-1:0]    acc, vstep_q;
  logic [HPOS_W-1:0]   start_q, end_q;

  // Span bounds at SIZE_W+1 bits so HALF+size never overflows before clamping.
  logic [EW-1:0] size_x, start_n, sum_n, end_n;
  assign size_x  = {1'b0, size};
  assign start_n = (size_x >= HALF_X) ? '0 : HALF_X - size_x;
  assign sum_n   = HALF_X + size_x;
  assign end_n   = (sum_n > LAST_X) ? LAST_X : sum_n;

  logic             hit_now;
  logic [TEX_W-1:0] tv;
  logic [5:0]       pix_rgb;
  assign hit_now = (state == INSIDE) || (state == ARMED && hpos == start_q);
  assign tv      = acc[ACC_W-1:FRAC_W];
  assign pix_rgb = mode ? (side_q ? 6'b11_11_11 : 6'b10_10_10)
                        : {texu_q[0] ^ tv[0], side_q, texu_q[2] ^ tv[2], side_q,
                           texu_q[4] ^ tv[4], side_q};

  // Only the even texu bits feed the pattern; the rest are latched but unread.
  logic unused_texu;
  assign unused_texu = ^texu_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      side_q  <= 1'b0;
      texu_q  <= '0;
      acc     <= '0;
      vstep_q <= '0;
      start_q <= '0;
      end_q   <= '0;
      rgb     <= '0;
      hit     <= 1'b0;
      texv    <= '0;
    end else if (line_start) begin
      state   <= ARMED;
      side_q  <= side;
      texu_q  <= texu;
      acc     <= vinit;
      vstep_q <= vstep;
      start_q <= HPOS_W'(start_n);
      end_q   <= HPOS_W'(end_n);
      rgb     <= '0;
      hit     <= 1'b0;
      texv    <= '0;
    end else if (px_en) begin
      hit  <= hit_now;
      texv <= hit_now ? tv : '0;
      rgb  <= hit_now ? pix_rgb : '0;
      if (hit_now) acc <= acc + vstep_q;
      case (state)
        ARMED: begin
          if (hpos == start_q)     state <= (hpos == end_q) ? DONE : INSIDE;
          else if (hpos > start_q) state <= DONE;
        end
        INSIDE: if (hpos == end_q) state <= DONE;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_row_render_seq.sv
// Directed bench for row_render_seq: span bounds, clamping, texture stepping,
// colour modes and mid-span events, against a small behavioural model.
module tb_row_render_seq;
  logic        clk = 1'b0;
  logic        reset, line_start, px_en, side, mode;
  logic [10:0] size;
  logic [5:0]  texu;
  logic [15:0] vinit, vstep;
  logic [9:0]  hpos;
  logic [5:0]  rgb;
  logic        hit;
  logic [5:0]  texv;

  row_render_seq dut (
    .clk(clk), .reset(reset), .line_start(line_start), .px_en(px_en),
    .side(side), .size(size), .texu(texu), .vinit(vinit), .vstep(vstep),
    .mode(mode), .hpos(hpos), .rgb(rgb), .hit(hit), .texv(texv)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Model of the current line
  int          m_start, m_end, hitcnt;
  logic        m_armed = 1'b0;
  logic [15:0] m_acc, m_vstep;
  logic        m_side;
  logic [5:0]  m_texu;

  task automatic start_line(input int sz, input logic [15:0] vi, input logic [15:0] vs,
                            input logic sd, input logic [5:0] tu, input int hp);
    line_start = 1'b1; px_en = 1'b1; hpos = 10'(hp);
    size = 11'(sz); vinit = vi; vstep = vs; side = sd; texu = tu;
    @(negedge clk);
    chk("ls_hit", 32'(hit), 32'd0);
    chk("ls_rgb", 32'(rgb), 32'd0);
    line_start = 1'b0;
    // scramble the latched inputs to show they are not sampled live
    size = 11'($urandom); vstep = 16'($urandom); side = ~sd; texu = ~tu;
    m_start = (sz >= 320) ? 0 : 320 - sz;
    m_end   = (320 + sz > 639) ? 639 : 320 + sz;
    m_armed = 1'b1; m_acc = vi; m_vstep = vs; m_side = sd; m_texu = tu;
    hitcnt  = 0;
  endtask

  task automatic pix(input int h);
    logic       eh;
    logic [5:0] etv, er;
    px_en = 1'b1; hpos = 10'(h);
    @(negedge clk);
    eh  = m_armed && h >= m_start && h <= m_end;
    etv = eh ? m_acc[15:10] : 6'd0;
    er  = !eh ? 6'd0 : mode ? (m_side ? 6'b111111 : 6'b101010)
        : {m_texu[0] ^ etv[0], m_side, m_texu[2] ^ etv[2], m_side, m_texu[4] ^ etv[4], m_side};
    chk($sformatf("hit@%0d", h), 32'(hit), 32'(eh));
    chk($sformatf("texv@%0d", h), 32'(texv), 32'(etv));
    chk($sformatf("rgb@%0d", h), 32'(rgb), 32'(er));
    if (eh) begin m_acc = m_acc + m_vstep; hitcnt++; end
    if (h >= m_end) m_armed = 1'b0;
  endtask

  task automatic sweep(input int lo, input int hi);
    for (int h = lo; h <= hi; h++) pix(h);
  endtask

  initial begin
    logic [5:0] prgb, ptv;
    logic       phit;
    reset = 1'b1; line_start = 1'b0; px_en = 1'b0; side = 1'b0; mode = 1'b0;
    size = '0; texu = '0; vinit = '0; vstep = '0; hpos = '0;

    // 1: reset with random inputs
    for (int i = 0; i < 3; i++) begin
      line_start = 1'($urandom); px_en = 1'($urandom); side = 1'($urandom);
      size = 11'($urandom); hpos = 10'($urandom_range(0, 639)); vinit = 16'($urandom);
      @(negedge clk);
      chk("rst_hit", 32'(hit), 32'd0);
      chk("rst_rgb", 32'(rgb), 32'd0);
      chk("rst_texv", 32'(texv), 32'd0);
    end
    reset = 1'b0; line_start = 1'b0;
    sweep(300, 340);

    // 2: span bounds, texv wraps 63->0 inside the 201-pixel span
    mode = 1'b0;
    start_line(100, 16'd0, 16'd1024, 1'b1, 6'b000101, 0);
    sweep(0, 639);
    chk("cnt_size100", 32'(hitcnt), 32'd201);
    start_line(0, 16'd0, 16'd1024, 1'b1, 6'b000101, 0);
    sweep(0, 319);
    pix(320);
    chk("rgb_xor_first", 32'(rgb), 32'b111101);
    sweep(321, 639);
    chk("cnt_size0", 32'(hitcnt), 32'd1);

    // 3: full width and clamp, nothing after the end
    start_line(320, 16'hFC00, 16'd1024, 1'b0, 6'b110011, 0);
    sweep(0, 639);
    chk("cnt_size320", 32'(hitcnt), 32'd640);
    sweep(0, 3);
    mode = 1'b1;
    start_line(2047, 16'd0, 16'd777, 1'b1, 6'b0, 0);
    sweep(0, 639);
    chk("cnt_size2047", 32'(hitcnt), 32'd640);
    sweep(0, 3);

    // 4: half-step texv, each value twice
    mode = 1'b0;
    start_line(5, 16'd0, 16'd512, 1'b0, 6'b010101, 0);
    sweep(0, 316);
    pix(317);
    chk("texv_half", 32'(texv), 32'd1);
    sweep(318, 639);
    chk("cnt_size5", 32'(hitcnt), 32'd11);

    // 5: flat shade
    mode = 1'b1;
    start_line(0, 16'd0, 16'd1024, 1'b0, 6'b111111, 0);
    sweep(0, 319);
    pix(320);
    chk("rgb_flat_side0", 32'(rgb), 32'b101010);
    sweep(321, 330);

    // 6a: px_en low mid-span holds outputs
    mode = 1'b0;
    start_line(100, 16'd0, 16'd1024, 1'b0, 6'b101010, 0);
    sweep(0, 249);
    prgb = rgb; ptv = texv; phit = hit;
    px_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      hpos = 10'($urandom_range(0, 639)); mode = 1'($urandom);
      @(negedge clk);
      chk("hold_hit", 32'(hit), 32'(phit));
      chk("hold_texv", 32'(texv), 32'(ptv));
      chk("hold_rgb", 32'(rgb), 32'(prgb));
    end
    mode = 1'b0;
    sweep(250, 639);
    chk("cnt_hold", 32'(hitcnt), 32'd201);

    // 6b: re-arm mid-span with a new size
    start_line(100, 16'd0, 16'd1024, 1'b1, 6'b000001, 0);
    sweep(0, 300);
    start_line(50, 16'd4096, 16'd2048, 1'b1, 6'b000100, 300);
    sweep(0, 639);
    chk("cnt_rearm", 32'(hitcnt), 32'd101);

    // 6c: reset mid-span
    start_line(100, 16'd0, 16'd1024, 1'b1, 6'b010000, 0);
    sweep(0, 300);
    reset = 1'b1; px_en = 1'b1; hpos = 10'd301;
    @(negedge clk);
    chk("rst_mid_hit", 32'(hit), 32'd0);
    chk("rst_mid_rgb", 32'(rgb), 32'd0);
    chk("rst_mid_texv", 32'(texv), 32'd0);
    reset = 1'b0; m_armed = 1'b0;
    sweep(302, 330);
    start_line(10, 16'd0, 16'd1024, 1'b0, 6'b0, 0);
    sweep(0, 639);
    chk("cnt_after_rst", 32'(hitcnt), 32'd21);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
